data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 12: word-address width; storage is 2**DEPTH_LOG2 32-bit words (4096 by default).
REQ-002 The module SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 m_data_addr  in  32  byte address from the CPU memory stage.
REQ-006 m_data_wdata  in  32  store data, already lane-aligned by the CPU.
REQ-007 m_data_byteen  in  4  per-byte write enables, bit 3 = bits 31:24; all zero = no store.
REQ-008 m_inst_addr  in  32  PC of the instruction issuing the access, used for trace only.
REQ-009 m_data_rdata  out  32  combinational read data for the word containing m_data_addr.
REQ-010 busy  out  1  high while the clear sequence runs; the CPU stalls memory accesses.
REQ-011 addr_err  out  1  one-cycle pulse flagging a dropped out-of-range store.
REQ-012 trace_valid  out  1, trace_pc  out  32, trace_addr  out  32, trace_data  out  32: store trace record.

Function
REQ-013 States SHALL be CLEAR and RUN; busy = (state == CLEAR).
REQ-014 In CLEAR with reset high, each cycle SHALL write 0 to word clr_cnt and then increment clr_cnt; after the write to word 2**DEPTH_LOG2-1 the state SHALL become RUN.
REQ-015 busy SHALL fall exactly 2**DEPTH_LOG2 rising edges after reset is released.
REQ-016 Range: an access is in range when m_data_addr < 4*2**DEPTH_LOG2; word index = m_data_addr[DEPTH_LOG2+1:2], and address bits 1:0 are ignored.
REQ-017 m_data_rdata SHALL equal the stored word for in-range addresses in RUN, and SHALL be 0 in CLEAR or when the address is out of range.
REQ-018 In RUN, an in-range access with nonzero byteen SHALL, at the rising edge, replace exactly the enabled byte lanes of the addressed word with the matching lanes of m_data_wdata; the other lanes are unchanged.
REQ-019 Read-during-store SHALL return the pre-store word in that cycle and the merged word from the next cycle.
REQ-020 In RUN, an out-of-range access with nonzero byteen SHALL be dropped and SHALL drive addr_err high for exactly the following cycle; all other cases SHALL drive addr_err low.
REQ-021 Stores presented in CLEAR SHALL be dropped silently: no memory change, no addr_err, no trace.
REQ-022 Back-to-back stores SHALL each complete in one cycle with no stall; RUN never asserts busy.

Reset
REQ-023 At any rising edge with reset low: state = CLEAR, clr_cnt = 0, busy = 1, addr_err = 0, and all trace outputs = 0.
REQ-024 While reset is held low, no memory word SHALL be written.
REQ-025 Reset asserted during CLEAR SHALL restart clearing from word 0.
REQ-026 Reset asserted during RUN SHALL discard all contents via a full clear sequence.

Configuration
REQ-027 Macro DATA_MEM_CTRL_TRACE_EN, when defined, SHALL enable the store-trace function described in REQ-028 and REQ-029.
REQ-028 With the macro defined: one cycle after each performed store, trace_valid = 1 for that cycle only. In the same cycle trace_pc = m_inst_addr, trace_addr = m_data_addr & 32'hfffffffc, and trace_data = the merged word.
REQ-029 With the macro defined: dropped stores SHALL produce no trace record.
REQ-030 Without the macro, all trace ports SHALL remain present but tied to 0, and no trace registers SHALL be built.

Verification
REQ-031 Hold reset low 3 cycles, then release -> busy = 1 for exactly 4096 edges, then 0; afterwards a read of 0x0, 0x10 or 0x3ffc returns 0x00000000.
REQ-032 In RUN, store addr 0x10, wdata 0x12345678, byteen 4'b1111, m_inst_addr 0x3004 -> next cycle rdata@0x10 = 0x12345678; with the trace macro, trace_valid = 1, trace_pc = 0x3004, trace_addr = 0x10, trace_data = 0x12345678.
REQ-033 Then store addr 0x12, wdata 0x0000AB00, byteen 4'b0010 -> rdata@0x10 = 0x1234AB78 and trace_addr = 0x10.
REQ-034 Store addr 0x4000, byteen 4'b1111 -> addr_err = 1 for one cycle, rdata@0x4000 = 0, no trace_valid, and word 0 unchanged.
REQ-035 Store addr 0x20, byteen 4'b1111, presented while busy = 1 -> after clear completes, rdata@0x20 = 0 and no addr_err or trace.
REQ-036 After REQ-032, pulse reset low 1 cycle mid-RUN -> busy high 4096 edges, then rdata@0x10 = 0; reset at clear edge 100 restarts the 4096-edge count.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU data memory with post-reset clear sequence, byte-lane stores and optional store trace (DATA_MEM_CTRL_TRACE_EN)
module data_mem_ctrl #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        busy,
    output logic        addr_err,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] clr_cnt;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  do_store;
    logic                  bad_store;
    logic [31:0]           rd_word;
    logic [31:0]           merged;

    assign idx          = m_data_addr[DEPTH_LOG2+1:2];
    assign in_range     = m_data_addr[31:DEPTH_LOG2+2] == '0;
    assign do_store     = state == RUN && in_range && |m_data_byteen;
    assign bad_store    = state == RUN && !in_range && |m_data_byteen;
    assign rd_word      = mem[idx];
    assign m_data_rdata = (state == RUN && in_range) ? rd_word : '0;
    assign busy         = state == CLEAR;

    // Overlay the enabled store lanes onto the currently stored word
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) merged[8*i+:8] = m_data_wdata[8*i+:8];
    end

    // Clear sequencer and out-of-range store flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= bad_store;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == '1) state <= RUN;
            end
        end
    end

    // Storage: zero one word per clear cycle, otherwise accept in-range stores; frozen during reset
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) mem[clr_cnt] <= '0;
            else if (do_store) mem[idx] <= merged;
        end
    end

`ifdef DATA_MEM_CTRL_TRACE_EN
    // Register a trace record one cycle after each performed store
    always_ff @(posedge clk) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= do_store;
            if (do_store) begin
                trace_pc   <= m_inst_addr;
                trace_addr <= m_data_addr & 32'hfffffffc;
                trace_data <= merged;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{m_data_addr[1:0], m_inst_addr};
    assign trace_valid = 1'b0;
    assign trace_pc    = '0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        busy;
    logic        addr_err;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    int          checks = 0;
    int          errors = 0;
    int          n;
    logic        seen;
    logic        tr_en;

    data_mem_ctrl dut (
        .clk(clk),
        .reset(reset),
        .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata),
        .busy(busy),
        .addr_err(addr_err),
        .trace_valid(trace_valid),
        .trace_pc(trace_pc),
        .trace_addr(trace_addr),
        .trace_data(trace_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        m_inst_addr   = pc;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        m_data_byteen = 4'b0;
        m_data_addr   = a;
        #1;
        check(tag, m_data_rdata, exp);
    endtask

    task automatic count_busy(output int cnt, output logic any_out);
        cnt     = 0;
        any_out = 1'b0;
        while (busy && cnt < 5000) begin
            tick();
            cnt++;
            any_out = any_out | addr_err | trace_valid;
        end
    endtask

    task automatic trace_chk(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_valid"}, {31'b0, trace_valid}, {31'b0, v & tr_en});
        check({tag, "_pc"}, trace_pc, tr_en ? pc : 32'h0);
        check({tag, "_addr"}, trace_addr, tr_en ? a : 32'h0);
        check({tag, "_data"}, trace_data, tr_en ? d : 32'h0);
    endtask

    initial begin
`ifdef DATA_MEM_CTRL_TRACE_EN
        tr_en = 1'b1;
`else
        tr_en = 1'b0;
`endif
        reset = 1'b0;
        store(32'h20, 32'hdeadbeef, 4'b1111, 32'h1000);
        repeat (3) tick();
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_addr_err", {31'b0, addr_err}, 32'h0);
        check("rst_rdata", m_data_rdata, 32'h0);
        trace_chk("rst_trace", 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        count_busy(n, seen);
        m_data_byteen = 4'b0;
        check("clear_edges", n, 4096);
        check("clear_quiet", {31'b0, seen}, 32'h0);
        read_chk("busy_store_dropped", 32'h20, 32'h0);
        read_chk("rd_0", 32'h0, 32'h0);
        read_chk("rd_10", 32'h10, 32'h0);
        read_chk("rd_3ffc", 32'h3ffc, 32'h0);
        store(32'h10, 32'h12345678, 4'b1111, 32'h3004);
        #1;
        check("rd_during_store", m_data_rdata, 32'h0);
        tick();
        m_data_byteen = 4'b0;
        #1;
        check("store_full", m_data_rdata, 32'h12345678);
        check("store_no_err", {31'b0, addr_err}, 32'h0);
        trace_chk("trace1", 1'b1, 32'h3004, 32'h10, 32'h12345678);
        tick();
        check("trace_one_cycle", {31'b0, trace_valid}, 32'h0);
        store(32'h12, 32'h0000ab00, 4'b0010, 32'h3008);
        tick();
        m_data_byteen = 4'b0;
        #1;
        check("lane_merge", m_data_rdata, 32'h1234ab78);
        trace_chk("trace2", 1'b1, 32'h3008, 32'h10, 32'h1234ab78);
        tick();
        store(32'h4000, 32'hffffffff, 4'b1111, 32'h300c);
        #1;
        check("oor_rdata", m_data_rdata, 32'h0);
        tick();
        m_data_byteen = 4'b0;
        #1;
        check("oor_err", {31'b0, addr_err}, 32'h1);
        check("oor_no_trace", {31'b0, trace_valid}, 32'h0);
        tick();
        check("oor_err_pulse", {31'b0, addr_err}, 32'h0);
        read_chk("oor_word0", 32'h0, 32'h0);
        read_chk("oor_word10", 32'h10, 32'h1234ab78);
        store(32'h20, 32'haaaaaaaa, 4'b1111, 32'h3010);
        tick();
        check("b2b_busy", {31'b0, busy}, 32'h0);
        store(32'h24, 32'h55000000, 4'b1000, 32'h3014);
        tick();
        check("b2b_busy2", {31'b0, busy}, 32'h0);
        store(32'h3ffc, 32'hcafef00d, 4'b1111, 32'h3018);
        tick();
        read_chk("b2b_20", 32'h20, 32'haaaaaaaa);
        read_chk("b2b_24", 32'h24, 32'h55000000);
        read_chk("top_word", 32'h3ffc, 32'hcafef00d);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rerst_busy", {31'b0, busy}, 32'h1);
        check("rerst_rdata", m_data_rdata, 32'h0);
        trace_chk("rerst_trace", 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (100) tick();
        check("mid_clear_busy", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        count_busy(n, seen);
        check("restart_edges", n, 4096);
        read_chk("rerst_10", 32'h10, 32'h0);
        read_chk("rerst_3ffc", 32'h3ffc, 32'h0);
        read_chk("rerst_20", 32'h20, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
